// File: rtl/ofifo_collect_pkg.sv
// Shared defaults for the systolic-array output collector.
// Pointer width carries one extra wrap bit above the storage address.
package ofifo_collect_pkg;

  localparam int def_col     = 8;
  localparam int def_psum_bw = 16;
  localparam int def_depth   = 64;

  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

  localparam int def_ptr_bw = ptr_width(def_depth);

endpackage

// File: rtl/ofifo_column.sv
// One column FIFO: circular storage, wrap-bit pointers, empty/full flags.
// `rd` is the already-accepted row read broadcast from the top level.
module ofifo_column
  import ofifo_collect_pkg::*;
#(
  parameter int psum_bw = def_psum_bw,
  parameter int depth   = def_depth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               drop
);

  localparam int ptr_bw  = ptr_width(depth);
  localparam int addr_bw = ptr_bw - 1;

  logic [psum_bw-1:0] mem [depth];
  logic [ptr_bw-1:0]  wptr;
  logic [ptr_bw-1:0]  rptr;
  logic               wr_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[addr_bw-1:0] == rptr[addr_bw-1:0]) &&
                 (wptr[addr_bw] != rptr[addr_bw]);

  // A same-cycle read frees the slot the write lands in, so full only blocks a lone write.
  assign wr_ok = wr && (!full || rd);
  assign drop  = wr && full && !rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd)    rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[addr_bw-1:0]] <= din;
  end

  assign dout = mem[rptr[addr_bw-1:0]];

endmodule

// File: rtl/ofifo_collect.sv
// Collects skewed per-column psums from the last array row and releases
// complete, column-aligned rows through a ready/read handshake.
module ofifo_collect
  import ofifo_collect_pkg::*;
#(
  parameter int col     = def_col,
  parameter int psum_bw = def_psum_bw,
  parameter int depth   = def_depth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid
);

  logic [col-1:0]         empty_vec;
  logic [col-1:0]         full_vec;
  logic [col-1:0]         drop_vec;
  logic [psum_bw*col-1:0] head;
  logic                   rd_acc;

  assign o_ready = ~|empty_vec;
  assign o_full  = |full_vec;
  assign rd_acc  = rd && o_ready;

  for (genvar g = 0; g < col; g++) begin : g_col
    ofifo_column #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[g]),
      .rd    (rd_acc),
      .din   (in[g*psum_bw +: psum_bw]),
      .dout  (head[g*psum_bw +: psum_bw]),
      .empty (empty_vec[g]),
      .full  (full_vec[g]),
      .drop  (drop_vec[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= rd_acc;
      if (rd_acc)    out        <= head;
      if (|drop_vec) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo_collect.sv
// Directed bench for ofifo_collect: reset, skewed fill, streaming,
// full/overflow, simultaneous access and mid-stream reset.
module tb_ofifo_collect;

  localparam int C  = 8;
  localparam int W  = 16;
  localparam int D  = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W*C-1:0] in = '0;
  logic [C-1:0]   wr = '0;
  logic           rd = 1'b0;
  logic           o_ready, o_full, o_overflow, o_valid;
  logic [W*C-1:0] out;

  int vectors = 0;
  int miscompares = 0;
  int popped;

  always #5 clk = ~clk;

  ofifo_collect #(.col(C), .psum_bw(W), .depth(D)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .o_ready    (o_ready),
    .o_full     (o_full),
    .o_overflow (o_overflow),
    .out        (out),
    .o_valid    (o_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*C-1:0] row_vec(input int base, input int r);
    logic [W*C-1:0] v;
    v = '0;
    for (int i = 0; i < C; i++) v[i*W +: W] = W'(base + r*16 + i);
    return v;
  endfunction

  // First wr[0] in cycle 10 after idle; last column written in cycle 17; ready in 18.
  task automatic skewed_fill(input string tag);
    logic [W*C-1:0] exp_row;
    exp_row = '0;
    for (int c = 0; c < 10; c++) tick();
    for (int i = 0; i < C; i++) begin
      check({tag, "_ready_low"}, 128'(o_ready), 128'(1'b0));
      wr = '0;
      wr[i] = 1'b1;
      in = '0;
      in[i*W +: W] = W'(16'h0100 + i);
      exp_row[i*W +: W] = W'(16'h0100 + i);
      tick();
    end
    wr = '0;
    in = '0;
    check({tag, "_ready_high"}, 128'(o_ready), 128'(1'b1));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check({tag, "_pop_valid"}, 128'(o_valid), 128'(1'b1));
    check({tag, "_pop_data"}, 128'(out), 128'(exp_row));
    check({tag, "_ready_after"}, 128'(o_ready), 128'(1'b0));
    tick();
    check({tag, "_valid_drop"}, 128'(o_valid), 128'(1'b0));
  endtask

  initial begin
    // reset, nothing driven
    tick();
    tick();
    check("rst_ready", 128'(o_ready), 128'(1'b0));
    check("rst_full",  128'(o_full),  128'(1'b0));
    check("rst_valid", 128'(o_valid), 128'(1'b0));
    check("rst_out",   128'(out),     128'(0));
    rst_n = 1'b1;
    tick();
    check("idle_ready", 128'(o_ready), 128'(1'b0));
    check("idle_ovf",   128'(o_overflow), 128'(1'b0));

    skewed_fill("fill1");

    // streaming: 100 skewed rows, rd held high
    popped = 0;
    rd = 1'b1;
    for (int t = 0; t < 130; t++) begin
      wr = '0;
      in = '0;
      for (int i = 0; i < C; i++) begin
        if (t - i >= 0 && t - i < 100) begin
          wr[i] = 1'b1;
          in[i*W +: W] = W'(16'h1000 + (t - i)*16 + i);
        end
      end
      tick();
      if (o_valid) begin
        check("stream_row", 128'(out), 128'(row_vec(16'h1000, popped)));
        popped++;
      end
    end
    rd = 1'b0;
    wr = '0;
    in = '0;
    check("stream_count", 128'(popped), 128'(100));
    check("stream_ovf",   128'(o_overflow), 128'(1'b0));
    check("stream_empty", 128'(o_ready), 128'(1'b0));

    // full and overflow
    for (int r = 0; r < D; r++) begin
      if (r == D - 1) check("full_before_last", 128'(o_full), 128'(1'b0));
      wr = '1;
      in = row_vec(16'h3000, r);
      tick();
    end
    check("full_set",    128'(o_full), 128'(1'b1));
    check("full_no_ovf", 128'(o_overflow), 128'(1'b0));
    in = '1;
    tick();
    wr = '0;
    in = '0;
    check("ovf_set",     128'(o_overflow), 128'(1'b1));
    check("ovf_full",    128'(o_full), 128'(1'b1));
    rd = 1'b1;
    for (int r = 0; r < D; r++) begin
      tick();
      check("drain_valid", 128'(o_valid), 128'(1'b1));
      check("drain_row",   128'(out), 128'(row_vec(16'h3000, r)));
    end
    check("drain_ready", 128'(o_ready), 128'(1'b0));
    check("drain_notfull", 128'(o_full), 128'(1'b0));
    tick();
    rd = 1'b0;
    check("drain_valid_drop", 128'(o_valid), 128'(1'b0));
    check("ovf_sticky", 128'(o_overflow), 128'(1'b1));

    // mid-stream reset: 6 rows in, pop one, 5 left buffered
    for (int r = 0; r < 6; r++) begin
      wr = '1;
      in = row_vec(16'h5000, r);
      tick();
    end
    wr = '0;
    in = '0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("pre_rst_valid", 128'(o_valid), 128'(1'b1));
    check("pre_rst_out",   128'(out), 128'(row_vec(16'h5000, 0)));
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", 128'(o_ready), 128'(1'b0));
    check("async_valid", 128'(o_valid), 128'(1'b0));
    check("async_out",   128'(out), 128'(0));
    check("async_ovf",   128'(o_overflow), 128'(1'b0));
    check("async_full",  128'(o_full), 128'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 128'(o_ready), 128'(1'b0));

    skewed_fill("fill2");

    // simultaneous write and read on full columns
    for (int r = 0; r < D; r++) begin
      wr = '1;
      in = row_vec(16'h6000, r);
      tick();
    end
    check("sim_full_pre", 128'(o_full), 128'(1'b1));
    wr = '1;
    rd = 1'b1;
    in = row_vec(16'h6000, D);
    tick();
    wr = '0;
    in = '0;
    check("sim_valid",   128'(o_valid), 128'(1'b1));
    check("sim_out",     128'(out), 128'(row_vec(16'h6000, 0)));
    check("sim_no_ovf",  128'(o_overflow), 128'(1'b0));
    check("sim_full",    128'(o_full), 128'(1'b1));
    for (int r = 1; r <= D; r++) begin
      tick();
      check("sim_drain_row", 128'(out), 128'(row_vec(16'h6000, r)));
    end
    check("sim_drain_ready", 128'(o_ready), 128'(1'b0));
    rd = 1'b0;
    tick();
    check("sim_valid_drop", 128'(o_valid), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
